// File: rtl/obf_key_scheduler.sv
// Key scheduler for the obfuscation datapath: handshakes plaintext words through
// the datapath one at a time and refreshes the global key with an LFSR every Period cycles.
module obf_key_scheduler #(
  parameter int                BitNo  = 64,
  parameter int                Period = 16,
  parameter logic [BitNo-1:0]  Seed   = 64'hACE1_0F0F_5A5A_1234
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [BitNo-1:0] DataIn,
  input  logic             InValid,
  output logic             InReady,
  input  logic [BitNo-1:0] InputKey,
  input  logic             KeyLoad,
  output logic [BitNo-1:0] ObfDataIn,
  output logic             ObfEN,
  output logic [BitNo-1:0] GKey,
  input  logic [BitNo-1:0] ObfDataOut,
  input  logic             ObfDataValid,
  output logic [BitNo-1:0] DataOut,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [15:0]      RekeyCount
);

  typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, HOLD, REKEY} state_t;

  localparam logic [15:0] LastCount = 16'(Period - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [BitNo-1:0] r_gKey;
  logic [BitNo-1:0] r_obfDataIn;
  logic [BitNo-1:0] r_dataOut;
  logic             r_outValid;
  logic [15:0]      r_refreshCnt;
  logic             r_pending;
  logic [15:0]      r_rekeyCount;
  logic             r_sampleValid;
  logic [BitNo-1:0] r_sampleData;

  logic             w_inReady;
  logic             w_accept;
  logic             w_capture;
  logic             w_release;
  logic             w_doRekey;
  logic             w_doLoad;
  logic [BitNo-1:0] w_lfsrNext;
  logic [BitNo-1:0] w_loadKey;

  assign w_lfsrNext = {r_gKey[BitNo-2:0],
                       r_gKey[BitNo-1] ^ r_gKey[BitNo-2] ^ r_gKey[BitNo-4] ^ r_gKey[BitNo-5]};
  // An all-zero key would lock the LFSR, so it falls back to the seed
  assign w_loadKey  = (InputKey == '0) ? Seed : InputKey;

  always_comb begin
    w_nextState = r_state;
    w_inReady   = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_doRekey   = 1'b0;
    w_doLoad    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_nextState = REKEY;
        end else if (KeyLoad) begin
          w_doLoad = 1'b1;
        end else begin
          w_inReady = 1'b1;
          if (InValid) begin
            w_accept    = 1'b1;
            w_nextState = ISSUE;
          end
        end
      end
      ISSUE:   w_nextState = CAPTURE;
      CAPTURE: begin
        if (r_sampleValid) begin
          w_capture   = 1'b1;
          w_nextState = HOLD;
        end else begin
          w_nextState = ISSUE;
        end
      end
      HOLD: begin
        if (OutReady) begin
          w_release   = 1'b1;
          w_nextState = IDLE;
        end
      end
      REKEY: begin
        w_doRekey   = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_gKey       <= Seed;
      r_rekeyCount <= '0;
    end else if (w_doRekey) begin
      r_gKey       <= w_lfsrNext;
      r_rekeyCount <= r_rekeyCount + 16'd1;
    end else if (w_doLoad) begin
      r_gKey       <= w_loadKey;
    end
  end

  // Counter keeps running through transactions and parks at LastCount until serviced
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_refreshCnt <= '0;
      r_pending    <= 1'b0;
    end else if (w_doRekey || w_doLoad) begin
      r_refreshCnt <= '0;
      r_pending    <= 1'b0;
    end else if (r_refreshCnt == LastCount) begin
      r_pending    <= 1'b1;
    end else begin
      r_refreshCnt <= r_refreshCnt + 16'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_obfDataIn   <= '0;
      r_dataOut     <= '0;
      r_outValid    <= 1'b0;
      r_sampleValid <= 1'b0;
      r_sampleData  <= '0;
    end else begin
      if (w_accept) r_obfDataIn <= DataIn;
      if (r_state == ISSUE) begin
        r_sampleValid <= ObfDataValid;
        r_sampleData  <= ObfDataOut;
      end
      if (w_capture) begin
        r_dataOut  <= r_sampleData;
        r_outValid <= 1'b1;
      end
      if (w_release) r_outValid <= 1'b0;
    end
  end

  assign InReady    = w_inReady;
  assign ObfDataIn  = r_obfDataIn;
  assign ObfEN      = (r_state == ISSUE);
  assign GKey       = r_gKey;
  assign DataOut    = r_dataOut;
  assign OutValid   = r_outValid;
  assign RekeyCount = r_rekeyCount;

endmodule

// File: tb/tb_obf_key_scheduler.sv
// Scoreboard bench for obf_key_scheduler: stimulus pushes expected results, a
// monitor pops them on each output handshake; key schedule checked directly.
module tb_obf_key_scheduler;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [63:0] DataIn = '0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [63:0] InputKey = '0;
  logic        KeyLoad = 1'b0;
  logic [63:0] ObfDataIn;
  logic        ObfEN;
  logic [63:0] GKey;
  logic [63:0] ObfDataOut;
  logic        ObfDataValid;
  logic [63:0] DataOut;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [15:0] RekeyCount;

  localparam logic [63:0] SeedVal = 64'hACE1_0F0F_5A5A_1234;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] expQ[$];
  logic [63:0] dpMask = '0;
  int          dpDrops = 0;
  logic        dpGo = 1'b0;
  int          enPulses = 0;

  obf_key_scheduler dut (
    .Clk(Clk), .Rst(Rst), .DataIn(DataIn), .InValid(InValid), .InReady(InReady),
    .InputKey(InputKey), .KeyLoad(KeyLoad), .ObfDataIn(ObfDataIn), .ObfEN(ObfEN),
    .GKey(GKey), .ObfDataOut(ObfDataOut), .ObfDataValid(ObfDataValid),
    .DataOut(DataOut), .OutValid(OutValid), .OutReady(OutReady), .RekeyCount(RekeyCount)
  );

  always #5 Clk = ~Clk;

  // Toy datapath: XOR with a mask, optionally refusing the first few ISSUE cycles
  assign ObfDataOut   = ObfDataIn ^ dpMask;
  assign ObfDataValid = ObfEN && dpGo;

  always @(negedge Clk) begin
    if (ObfEN) begin
      enPulses++;
      dpGo = (dpDrops == 0);
      if (dpDrops > 0) dpDrops--;
    end
  end

  always @(negedge Clk) begin
    if (!Rst && OutValid && OutReady) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL monitor: unexpected output actual=%h required=none", DataOut);
      end else begin
        logic [63:0] exp;
        exp = expQ.pop_front();
        if (DataOut !== exp) begin
          errors++;
          $display("[TB] FAIL monitor: DataOut actual=%h required=%h", DataOut, exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] lfsrModel(input logic [63:0] k);
    return {k[62:0], k[63] ^ k[62] ^ k[60] ^ k[59]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] data, input logic [63:0] mask,
                               input int drops, input logic [63:0] expected);
    int n = 0;
    @(posedge Clk); #1;
    DataIn  = data;
    InValid = 1'b1;
    dpMask  = mask;
    dpDrops = drops;
    expQ.push_back(expected);
    do begin @(negedge Clk); n++; end while (!InReady && n < 40);
    checkOutput("accept", 64'(InReady), 64'd1);
    @(posedge Clk); #1;
    InValid = 1'b0;
  endtask

  task automatic waitOutput(input string name);
    int n = 0;
    do begin @(negedge Clk); n++; end while (!OutValid && n < 20);
    checkOutput(name, 64'(OutValid), 64'd1);
  endtask

  initial begin
    logic [63:0] gk0;
    logic [15:0] rc0;
    int          lowCount;
    int          firstLow;
    logic [63:0] gk17, gk18;
    bit          keyStable, holdStable;
    int          validSeen;

    // Reset values while Rst is held
    repeat (2) @(negedge Clk);
    checkOutput("rst_gkey", GKey, SeedVal);
    checkOutput("rst_obfdatain", ObfDataIn, 64'd0);
    checkOutput("rst_dataout", DataOut, 64'd0);
    checkOutput("rst_outvalid", 64'(OutValid), 64'd0);
    checkOutput("rst_obfen", 64'(ObfEN), 64'd0);
    checkOutput("rst_rekeycount", 64'(RekeyCount), 64'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;

    // Idle rekey: pending in cycle 16, REKEY in cycle 17
    lowCount = 0; firstLow = -1; gk17 = '0; gk18 = '0;
    for (int k = 0; k < 22; k++) begin
      @(negedge Clk);
      if (k == 0) checkOutput("inready_first", 64'(InReady), 64'd1);
      if (!InReady) begin
        lowCount++;
        if (firstLow < 0) firstLow = k;
      end
      if (k == 17) gk17 = GKey;
      if (k == 18) gk18 = GKey;
    end
    checkOutput("rekey_low_cycles", 64'(lowCount), 64'd2);
    checkOutput("rekey_first_low", 64'(firstLow), 64'd16);
    checkOutput("rekey_gkey_before", gk17, SeedVal);
    checkOutput("rekey_gkey_after", gk18, 64'h59C2_1E1E_B4B4_2468);
    checkOutput("rekey_count1", 64'(RekeyCount), 64'd1);

    // Key loads: zero key falls back to seed, counter restarts
    @(posedge Clk); #1;
    KeyLoad = 1'b1; InputKey = 64'd0;
    @(negedge Clk);
    checkOutput("keyload_inready", 64'(InReady), 64'd0);
    @(posedge Clk); #1;
    KeyLoad = 1'b0;
    @(negedge Clk);
    checkOutput("keyload_zero", GKey, SeedVal);
    checkOutput("keyload_rekeycount", 64'(RekeyCount), 64'd1);
    @(posedge Clk); #1;
    KeyLoad = 1'b1; InputKey = 64'hFFFF_0000_FFFF_0000;
    @(posedge Clk); #1;
    KeyLoad = 1'b0;
    @(negedge Clk);
    checkOutput("keyload_value", GKey, 64'hFFFF_0000_FFFF_0000);
    repeat (15) @(negedge Clk);
    checkOutput("restart_not_yet", 64'(InReady), 64'd1);
    @(negedge Clk);
    checkOutput("restart_pending", 64'(InReady), 64'd0);
    @(negedge Clk);
    checkOutput("restart_key_held", GKey, 64'hFFFF_0000_FFFF_0000);
    @(negedge Clk);
    checkOutput("restart_key_step", GKey, 64'hFFFE_0001_FFFE_0000);
    checkOutput("restart_count2", 64'(RekeyCount), 64'd2);

    // Echo transaction with latency and single enable pulse
    enPulses = 0;
    applyStimulus(64'h1, 64'h0, 0, 64'h1);
    @(negedge Clk);
    checkOutput("issue_obfen", 64'(ObfEN), 64'd1);
    checkOutput("issue_obfdatain", ObfDataIn, 64'h1);
    checkOutput("issue_outvalid", 64'(OutValid), 64'd0);
    @(negedge Clk);
    checkOutput("capture_obfen", 64'(ObfEN), 64'd0);
    checkOutput("capture_outvalid", 64'(OutValid), 64'd0);
    @(negedge Clk);
    checkOutput("latency_outvalid", 64'(OutValid), 64'd1);
    @(negedge Clk);
    checkOutput("release_outvalid", 64'(OutValid), 64'd0);
    checkOutput("dataout_retained", DataOut, 64'h1);
    checkOutput("echo_enpulses", 64'(enPulses), 64'd1);

    // Retry: datapath refuses the first ISSUE
    enPulses = 0;
    applyStimulus(64'hDEAD_BEEF_0000_FFFF, 64'h0123_4567_89AB_CDEF, 1, 64'hDF8E_FB88_89AB_3210);
    waitOutput("retry_outvalid");
    @(negedge Clk);
    checkOutput("retry_enpulses", 64'(enPulses), 64'd2);

    // Refresh falls due while HOLD stalls; rekey runs before the next accept
    OutReady = 1'b0;
    applyStimulus(64'h0000_0000_CAFE_F00D, 64'hFFFF_FFFF_0000_0000, 0, 64'hFFFF_FFFF_CAFE_F00D);
    waitOutput("hold_outvalid");
    gk0 = GKey; rc0 = RekeyCount; keyStable = 1'b1; holdStable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (GKey !== gk0) keyStable = 1'b0;
      if (!OutValid || DataOut !== 64'hFFFF_FFFF_CAFE_F00D) holdStable = 1'b0;
    end
    checkOutput("hold_key_stable", 64'(keyStable), 64'd1);
    checkOutput("hold_output_stable", 64'(holdStable), 64'd1);
    checkOutput("hold_no_rekey", 64'(RekeyCount), 64'(rc0));
    @(posedge Clk); #1;
    OutReady = 1'b1;
    DataIn = 64'h5555_AAAA_5555_AAAA; InValid = 1'b1; dpMask = 64'h0; dpDrops = 0;
    expQ.push_back(64'h5555_AAAA_5555_AAAA);
    @(negedge Clk);
    @(negedge Clk);
    checkOutput("post_hold_inready", 64'(InReady), 64'd0);
    checkOutput("post_hold_outvalid", 64'(OutValid), 64'd0);
    checkOutput("post_hold_dataout", DataOut, 64'hFFFF_FFFF_CAFE_F00D);
    checkOutput("post_hold_gkey", GKey, gk0);
    validSeen = 0;
    while (!InReady && validSeen < 10) begin @(negedge Clk); validSeen++; end
    checkOutput("rekey_before_accept_cnt", 64'(RekeyCount), 64'(rc0 + 16'd1));
    checkOutput("rekey_before_accept_key", GKey, lfsrModel(gk0));
    @(posedge Clk); #1;
    InValid = 1'b0;
    waitOutput("post_rekey_outvalid");

    // Reset in CAPTURE discards the word
    applyStimulus(64'h0000_0000_0000_1234, 64'h0, 0, 64'h1234);
    @(negedge Clk);
    @(negedge Clk);
    Rst = 1'b1;
    expQ.delete();
    #1;
    checkOutput("midrst_outvalid", 64'(OutValid), 64'd0);
    checkOutput("midrst_obfen", 64'(ObfEN), 64'd0);
    checkOutput("midrst_gkey", GKey, SeedVal);
    checkOutput("midrst_obfdatain", ObfDataIn, 64'd0);
    checkOutput("midrst_dataout", DataOut, 64'd0);
    checkOutput("midrst_rekeycount", 64'(RekeyCount), 64'd0);
    repeat (2) @(posedge Clk); #1;
    Rst = 1'b0;
    validSeen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (OutValid) validSeen++;
    end
    checkOutput("midrst_no_outvalid", 64'(validSeen), 64'd0);
    checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
